// File: rtl/irrigacao_pkg.sv
// Shared definitions for the multi-zone irrigation controller.
// Holds the state encoding (codes 5..7 are illegal) and the error codes
// reported on err_code.
package irrigacao_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ENCHENDO  = 3'd0;
  localparam state_t CHEIO     = 3'd1;
  localparam state_t IRRIGANDO = 3'd2;
  localparam state_t LIMPEZA   = 3'd3;
  localparam state_t ERRO      = 3'd4;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_LEVEL   = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;

endpackage

// File: rtl/irrigacao_multizona_rr_arbiter.sv
// Combinational round-robin arbiter.
// Grants the first active request at or after ptr, wrapping N-1 -> 0.
// The pointer register is kept by the parent.
// Ports:
//   req       in  N      active request per zone
//   ptr       in  IDX_W  search start index (must be < N)
//   grant     out N      one-hot grant, zero when nothing requests
//   grant_idx out IDX_W  index of the granted zone
//   any       out 1      at least one request active
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             any
);

  int p;
  int pick;

  // Both loops walk downwards so the last hit is the lowest index.
  // The second loop (indices >= ptr) overrides the wrapped search.
  always_comb begin
    p    = int'(ptr);
    pick = -1;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i] && (i < p)) pick = i;
    end
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i] && (i >= p)) pick = i;
    end
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (pick == i) begin
        grant[i]  = 1'b1;
        grant_idx = IDX_W'(i);
        any       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/irrigacao_multizona.sv
// Multi-zone irrigation controller: one reservoir feeding N_ZONES zones,
// each requesting drip (req_got) or sprinkler (req_asp) watering.
// Round-robin zone arbitration, timed irrigation and cleaning, fill
// timeout and debounced exit from the error state.
// Ports:
//   clk, reset_n          clock (rising edge), async active-low reset
//   cheio, erro_nivel     tank-full sensor, level-sensor fault
//   req_got, req_asp      per-zone drip / sprinkler requests (level-held)
//   state                 current state code
//   valvula               one-hot open valve, only while IRRIGANDO
//   modo_asp              1 = sprinkler for the open valve
//   enchendo_saida, limpeza_saida, erro_saida  state decodes
//   err_code              error cause while in ERRO, else 0
module irrigacao_multizona
  import irrigacao_pkg::*;
#(
  parameter int N_ZONES      = 4,
  parameter int IRR_CYCLES   = 8,
  parameter int CLEAN_CYCLES = 4,
  parameter int FILL_TIMEOUT = 16,
  parameter int ERR_HOLD     = 3
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               cheio,
  input  logic               erro_nivel,
  input  logic [N_ZONES-1:0] req_got,
  input  logic [N_ZONES-1:0] req_asp,
  output logic [2:0]         state,
  output logic [N_ZONES-1:0] valvula,
  output logic               modo_asp,
  output logic               enchendo_saida,
  output logic               limpeza_saida,
  output logic               erro_saida,
  output logic [1:0]         err_code
);

  localparam int IDX_W   = (N_ZONES > 1) ? $clog2(N_ZONES) : 1;
  localparam int FILL_W  = $clog2(FILL_TIMEOUT + 1);
  localparam int IRR_W   = $clog2(IRR_CYCLES + 1);
  localparam int CLEAN_W = $clog2(CLEAN_CYCLES + 1);
  localparam int OK_W    = $clog2(ERR_HOLD + 1);

  state_t             cur_state, nxt_state;
  logic [1:0]         cur_err, nxt_err;
  logic [IDX_W-1:0]   cur_zone, nxt_zone;
  logic [IDX_W-1:0]   cur_ptr, nxt_ptr;
  logic               cur_mode, nxt_mode;
  logic [FILL_W-1:0]  fill_cnt, nxt_fill;
  logic [IRR_W-1:0]   irr_cnt, nxt_irr;
  logic [CLEAN_W-1:0] clean_cnt, nxt_clean;
  logic [OK_W-1:0]    ok_cnt, nxt_ok;

  logic [N_ZONES-1:0] active;
  logic [N_ZONES-1:0] grant;
  logic [IDX_W-1:0]   grant_idx;
  logic               any_req;
  logic               keep_req;

  assign active = req_got | req_asp;

  rr_arbiter #(.N(N_ZONES), .IDX_W(IDX_W)) u_arb (
    .req       (active),
    .ptr       (cur_ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any       (any_req)
  );

  // Irrigation continues only while the request of the latched mode holds.
  assign keep_req = cur_mode ? req_asp[cur_zone] : req_got[cur_zone];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cur_state <= ENCHENDO;
      cur_err   <= ERR_NONE;
      cur_zone  <= '0;
      cur_ptr   <= '0;
      cur_mode  <= 1'b0;
      fill_cnt  <= '0;
      irr_cnt   <= '0;
      clean_cnt <= '0;
      ok_cnt    <= '0;
    end else begin
      cur_state <= nxt_state;
      cur_err   <= nxt_err;
      cur_zone  <= nxt_zone;
      cur_ptr   <= nxt_ptr;
      cur_mode  <= nxt_mode;
      fill_cnt  <= nxt_fill;
      irr_cnt   <= nxt_irr;
      clean_cnt <= nxt_clean;
      ok_cnt    <= nxt_ok;
    end
  end

  always_comb begin
    nxt_state = cur_state;
    nxt_err   = cur_err;
    nxt_zone  = cur_zone;
    nxt_ptr   = cur_ptr;
    nxt_mode  = cur_mode;
    nxt_fill  = fill_cnt;
    nxt_irr   = irr_cnt;
    nxt_clean = clean_cnt;
    nxt_ok    = ok_cnt;

    if ((cur_state != ERRO) && erro_nivel) begin
      nxt_state = ERRO;
      nxt_err   = ERR_LEVEL;
    end else begin
      case (cur_state)
        ENCHENDO: begin
          if (cheio) begin
            nxt_state = CHEIO;
          end else if (fill_cnt == FILL_W'(FILL_TIMEOUT - 1)) begin
            nxt_state = ERRO;
            nxt_err   = ERR_TIMEOUT;
          end else begin
            nxt_fill = fill_cnt + 1'b1;
          end
        end
        CHEIO: begin
          if (any_req) begin
            nxt_state = IRRIGANDO;
            nxt_zone  = grant_idx;
            // Drip wins when both requests of the granted zone are set.
            nxt_mode  = |(req_asp & ~req_got & grant);
            nxt_ptr   = (grant_idx == IDX_W'(N_ZONES - 1)) ? '0 : grant_idx + 1'b1;
          end
        end
        IRRIGANDO: begin
          if (!keep_req || (irr_cnt == IRR_W'(IRR_CYCLES - 1))) begin
            nxt_state = LIMPEZA;
          end else begin
            nxt_irr = irr_cnt + 1'b1;
          end
        end
        LIMPEZA: begin
          if (clean_cnt == CLEAN_W'(CLEAN_CYCLES - 1)) begin
            nxt_state = cheio ? CHEIO : ENCHENDO;
          end else begin
            nxt_clean = clean_cnt + 1'b1;
          end
        end
        ERRO: begin
          if (erro_nivel) begin
            nxt_ok = '0;
          end else if (ok_cnt == OK_W'(ERR_HOLD - 1)) begin
            nxt_state = cheio ? CHEIO : ENCHENDO;
            nxt_err   = ERR_NONE;
          end else begin
            nxt_ok = ok_cnt + 1'b1;
          end
        end
        default: begin
          nxt_state = ERRO;
          nxt_err   = ERR_LEVEL;
        end
      endcase
    end

    // Every counter starts from zero in the state being entered.
    if (nxt_state != cur_state) begin
      nxt_fill  = '0;
      nxt_irr   = '0;
      nxt_clean = '0;
      nxt_ok    = '0;
    end
  end

  always_comb begin
    state          = cur_state;
    valvula        = '0;
    if (cur_state == IRRIGANDO) valvula[cur_zone] = 1'b1;
    modo_asp       = (cur_state == IRRIGANDO) && cur_mode;
    enchendo_saida = (cur_state == ENCHENDO);
    limpeza_saida  = (cur_state == LIMPEZA);
    erro_saida     = (cur_state == ERRO);
    err_code       = (cur_state == ERRO) ? cur_err : ERR_NONE;
  end

endmodule

// File: tb/tb_irrigacao_multizona.sv
// Directed testbench for irrigacao_multizona (default parameters).
module tb_irrigacao_multizona;

  logic       clk;
  logic       reset_n;
  logic       cheio;
  logic       erro_nivel;
  logic [3:0] req_got;
  logic [3:0] req_asp;
  logic [2:0] state;
  logic [3:0] valvula;
  logic       modo_asp;
  logic       enchendo_saida;
  logic       limpeza_saida;
  logic       erro_saida;
  logic [1:0] err_code;

  int total;
  int bad;

  irrigacao_multizona dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .cheio          (cheio),
    .erro_nivel     (erro_nivel),
    .req_got        (req_got),
    .req_asp        (req_asp),
    .state          (state),
    .valvula        (valvula),
    .modo_asp       (modo_asp),
    .enchendo_saida (enchendo_saida),
    .limpeza_saida  (limpeza_saida),
    .erro_saida     (erro_saida),
    .err_code       (err_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; cheio = 1'b0; erro_nivel = 1'b0; req_got = 4'b0; req_asp = 4'b0;
    step(2);
    total++; if (state !== 3'd0) begin bad++; $display("FAIL reset_state got=%0d want=0", state); end
    total++; if (valvula !== 4'b0000) begin bad++; $display("FAIL reset_valvula got=%b want=0000", valvula); end
    total++; if (err_code !== 2'd0) begin bad++; $display("FAIL reset_err_code got=%0d want=0", err_code); end
    total++; if ({enchendo_saida, limpeza_saida, erro_saida} !== 3'b100) begin bad++; $display("FAIL reset_flags got=%b want=100", {enchendo_saida, limpeza_saida, erro_saida}); end
    reset_n = 1'b1;
  endtask

  task automatic test_fill();
    step(2);
    total++; if (state !== 3'd0) begin bad++; $display("FAIL fill_wait got=%0d want=0", state); end
    cheio = 1'b1;
    step(1);
    total++; if (state !== 3'd1) begin bad++; $display("FAIL fill_to_cheio got=%0d want=1", state); end
    step(3);
    total++; if (state !== 3'd1) begin bad++; $display("FAIL cheio_idle got=%0d want=1", state); end
    total++; if (valvula !== 4'b0000) begin bad++; $display("FAIL cheio_valvula got=%b want=0000", valvula); end
    total++; if (enchendo_saida !== 1'b0) begin bad++; $display("FAIL cheio_enchendo got=%b want=0", enchendo_saida); end
  endtask

  task automatic test_round_robin();
    req_got = 4'b1010;
    step(1);
    total++; if (state !== 3'd2) begin bad++; $display("FAIL rr_irr_state got=%0d want=2", state); end
    total++; if (valvula !== 4'b0010) begin bad++; $display("FAIL rr_first_zone got=%b want=0010", valvula); end
    total++; if (modo_asp !== 1'b0) begin bad++; $display("FAIL rr_modo got=%b want=0", modo_asp); end
    step(7);
    total++; if (state !== 3'd2) begin bad++; $display("FAIL rr_irr_last got=%0d want=2", state); end
    step(1);
    total++; if (state !== 3'd3) begin bad++; $display("FAIL rr_timer_expiry got=%0d want=3", state); end
    total++; if ({valvula, limpeza_saida} !== 5'b00001) begin bad++; $display("FAIL rr_limpeza_out got=%b want=00001", {valvula, limpeza_saida}); end
    step(3);
    total++; if (state !== 3'd3) begin bad++; $display("FAIL rr_clean_last got=%0d want=3", state); end
    step(1);
    total++; if (state !== 3'd1) begin bad++; $display("FAIL rr_clean_done got=%0d want=1", state); end
    step(1);
    total++; if (valvula !== 4'b1000) begin bad++; $display("FAIL rr_second_zone got=%b want=1000", valvula); end
    req_got = 4'b0000;
    step(1);
    total++; if (state !== 3'd3) begin bad++; $display("FAIL rr_drop got=%0d want=3", state); end
    step(4);
    total++; if (state !== 3'd1) begin bad++; $display("FAIL rr_back_cheio got=%0d want=1", state); end
  endtask

  task automatic test_sprinkler();
    req_asp = 4'b0100;
    step(1);
    total++; if (valvula !== 4'b0100) begin bad++; $display("FAIL asp_zone got=%b want=0100", valvula); end
    total++; if (modo_asp !== 1'b1) begin bad++; $display("FAIL asp_modo got=%b want=1", modo_asp); end
    step(2);
    total++; if ({state, modo_asp} !== 4'b0101) begin bad++; $display("FAIL asp_third_cycle got=%b want=0101", {state, modo_asp}); end
    req_asp = 4'b0000;
    step(1);
    total++; if (state !== 3'd3) begin bad++; $display("FAIL asp_drop got=%0d want=3", state); end
    total++; if (modo_asp !== 1'b0) begin bad++; $display("FAIL asp_modo_off got=%b want=0", modo_asp); end
    step(4);
    // Pointer is 3 here; zone 3 idle, so the search wraps to zone 2.
    req_got = 4'b0100; req_asp = 4'b0100;
    step(1);
    total++; if (valvula !== 4'b0100) begin bad++; $display("FAIL tie_zone got=%b want=0100", valvula); end
    total++; if (modo_asp !== 1'b0) begin bad++; $display("FAIL tie_drip_wins got=%b want=0", modo_asp); end
    req_got = 4'b0000;
    step(1);
    total++; if (state !== 3'd3) begin bad++; $display("FAIL tie_drip_drop got=%0d want=3", state); end
    req_asp = 4'b0000;
    step(4);
    total++; if (state !== 3'd1) begin bad++; $display("FAIL tie_back_cheio got=%0d want=1", state); end
  endtask

  task automatic test_fill_timeout();
    reset_n = 1'b0; cheio = 1'b0;
    step(1);
    reset_n = 1'b1;
    step(15);
    total++; if (state !== 3'd0) begin bad++; $display("FAIL to_before got=%0d want=0", state); end
    step(1);
    total++; if (state !== 3'd4) begin bad++; $display("FAIL to_erro got=%0d want=4", state); end
    total++; if (err_code !== 2'd2) begin bad++; $display("FAIL to_code got=%0d want=2", err_code); end
    total++; if (erro_saida !== 1'b1) begin bad++; $display("FAIL to_erro_saida got=%b want=1", erro_saida); end
    step(2);
    total++; if (state !== 3'd4) begin bad++; $display("FAIL to_hold got=%0d want=4", state); end
    step(1);
    total++; if (state !== 3'd0) begin bad++; $display("FAIL to_exit got=%0d want=0", state); end
    total++; if (err_code !== 2'd0) begin bad++; $display("FAIL to_code_clear got=%0d want=0", err_code); end
  endtask

  task automatic test_level_error();
    cheio = 1'b1;
    step(1);
    total++; if (state !== 3'd1) begin bad++; $display("FAIL le_cheio got=%0d want=1", state); end
    req_got = 4'b0001;
    step(2);
    total++; if (valvula !== 4'b0001) begin bad++; $display("FAIL le_irr got=%b want=0001", valvula); end
    erro_nivel = 1'b1; req_got = 4'b0000;
    step(1);
    total++; if ({state, err_code} !== 5'b10001) begin bad++; $display("FAIL le_enter got=%b want=10001", {state, err_code}); end
    total++; if (valvula !== 4'b0000) begin bad++; $display("FAIL le_valvula got=%b want=0000", valvula); end
    erro_nivel = 1'b0; step(1);
    erro_nivel = 1'b0; step(1);
    erro_nivel = 1'b1; step(1);
    total++; if (state !== 3'd4) begin bad++; $display("FAIL le_bounce got=%0d want=4", state); end
    erro_nivel = 1'b0; step(2);
    total++; if (state !== 3'd4) begin bad++; $display("FAIL le_debounce got=%0d want=4", state); end
    step(1);
    total++; if ({state, err_code} !== 5'b00100) begin bad++; $display("FAIL le_exit got=%b want=00100", {state, err_code}); end
  endtask

  task automatic test_async_reset();
    // Pointer is 1 after zone 0 was granted.
    req_got = 4'b0010;
    step(1);
    total++; if (valvula !== 4'b0010) begin bad++; $display("FAIL ar_irr got=%b want=0010", valvula); end
    #3 reset_n = 1'b0;
    #1;
    total++; if (state !== 3'd0) begin bad++; $display("FAIL ar_state got=%0d want=0", state); end
    total++; if (valvula !== 4'b0000) begin bad++; $display("FAIL ar_valvula got=%b want=0000", valvula); end
    req_got = 4'b0000;
    step(1);
    reset_n = 1'b1;
    step(1);
    total++; if (state !== 3'd1) begin bad++; $display("FAIL ar_refill got=%0d want=1", state); end
    erro_nivel = 1'b1; req_got = 4'b0001;
    step(1);
    total++; if ({state, err_code} !== 5'b10001) begin bad++; $display("FAIL ar_err_priority got=%b want=10001", {state, err_code}); end
    total++; if (valvula !== 4'b0000) begin bad++; $display("FAIL ar_err_valvula got=%b want=0000", valvula); end
    erro_nivel = 1'b0; req_got = 4'b0000;
    step(3);
    total++; if (state !== 3'd1) begin bad++; $display("FAIL ar_err_exit got=%0d want=1", state); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_fill();
    test_round_robin();
    test_sprinkler();
    test_fill_timeout();
    test_level_error();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/irrigacao_multizona.md
Name: irrigacao_multizona

Overview:
- Parametrised successor to the single-line irrigation FSM.
- Controls one reservoir feeding N_ZONES irrigation zones. Each zone can request drip (gotejamento) or sprinkler (aspersao) watering.
- Adds round-robin zone arbitration, timed irrigation, timed cleaning, a fill timeout and error-exit debounce. Sits between the sensor/request inputs and the valve/display drivers.

Parameters:
N_ZONES, 4, number of zones (1..16)
IRR_CYCLES, 8, maximum irrigation duration per grant, in clk cycles (>=1)
CLEAN_CYCLES, 4, cleaning duration in clk cycles (>=1)
FILL_TIMEOUT, 16, maximum cycles in FILL before a timeout error (>=2)
ERR_HOLD, 3, consecutive cycles erro_nivel must be low before leaving ERRO (>=1)

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  reset, asynchronous, active-low
cheio  in  1  tank-full sensor
erro_nivel  in  1  level-sensor fault
req_got  in  N_ZONES  per-zone drip request, level-held
req_asp  in  N_ZONES  per-zone sprinkler request, level-held
state  out  3  current state encoding
valvula  out  N_ZONES  one-hot zone valve; nonzero only in IRRIGANDO
modo_asp  out  1  1=sprinkler, 0=drip; valid in IRRIGANDO, else 0
enchendo_saida  out  1  state==ENCHENDO
limpeza_saida  out  1  state==LIMPEZA
erro_saida  out  1  state==ERRO
err_code  out  2  0 none, 1 level fault, 2 fill timeout; held while in ERRO, 0 elsewhere

Behaviour:
- Clock and reset: one clock. reset_n is asynchronous and active-low.
- Reset values: state=ENCHENDO; all counters 0; RR pointer 0; latched zone 0; latched mode 0; err_code 0.
- Outputs: all are a combinational decode of registered state and latches, so they track state with no extra latency.
- Encodings: ENCHENDO=0, CHEIO=1, IRRIGANDO=2, LIMPEZA=3, ERRO=4. Codes 5-7 are illegal and go to ERRO with err_code=1.
- Error priority: in every non-ERRO state, erro_nivel=1 takes priority over all other transitions. Next state is ERRO with err_code=1.
- ENCHENDO:
  - cheio=1 -> CHEIO.
  - Otherwise fill_cnt increments. When fill_cnt==FILL_TIMEOUT-1 and cheio=0 -> ERRO with err_code=2.
  - fill_cnt clears on exit.
- CHEIO:
  - Active request vector per zone z = req_got[z] | req_asp[z].
  - If any zone is active, the arbiter grants the first active zone at or after the RR pointer, wrapping N_ZONES-1 to 0.
  - On grant: latch the zone; latch mode (modo_asp = req_asp[z] & ~req_got[z], so drip wins a tie); set pointer = (z+1) mod N_ZONES; go to IRRIGANDO.
  - No request -> stay in CHEIO.
- IRRIGANDO:
  - valvula = 1<<zone.
  - irr_cnt increments from 0.
  - Go to LIMPEZA when the latched-mode request of the latched zone drops, or when irr_cnt==IRR_CYCLES-1, whichever comes first.
  - Requests from other zones are ignored.
- LIMPEZA:
  - clean_cnt increments.
  - When clean_cnt==CLEAN_CYCLES-1: go to CHEIO if cheio=1, else ENCHENDO.
  - A zone request cannot shorten cleaning.
- ERRO:
  - ok_cnt counts consecutive cycles with erro_nivel=0 and resets to 0 whenever erro_nivel=1.
  - When ok_cnt==ERR_HOLD-1 and erro_nivel=0: go to CHEIO if cheio=1, else ENCHENDO.
  - err_code clears on exit.
  - A fill timeout with a good sensor exits after ERR_HOLD cycles.
- Counters: every state counter clears on entering its state. Width is $clog2(max parameter + 1). Counters never wrap.
- Simultaneous events: erro_nivel beats cheio, requests and timer expiry. Drip/sprinkler tie is resolved to drip. In IRRIGANDO, request drop and timer expiry together -> LIMPEZA (same result).
- Reset mid-operation: everything returns to reset values immediately, and all valves close asynchronously.

Decomposition:
- Shared package irrigacao_pkg: state encoding localparams (ENCHENDO..ERRO) and ERR_NONE/ERR_LEVEL/ERR_TIMEOUT codes.
- One sub-module, rr_arbiter: parameter N. Inputs: req[N], ptr. Outputs: grant one-hot, grant_idx, any. Purely combinational, so the pointer register stays in the parent.

Test Plan:
All scenarios use defaults unless stated.
1. Reset then cheio=1 at cycle 3 -> state 0->1; no request -> holds 1 with valvula=0.
2. In CHEIO, req_got=4'b1010 and pointer=0 -> zone 1 granted, valvula=0010, modo_asp=0. Request held -> after 8 cycles LIMPEZA, after 4 more cycles CHEIO (cheio=1). Next grant is zone 3 (valvula=1000).
3. req_asp[2]=1 alone, dropped after 3 IRRIGANDO cycles -> LIMPEZA on the next edge, modo_asp=1 during irrigation. req_got[2]&req_asp[2] together -> modo_asp=0.
4. ENCHENDO with cheio=0 for 16 cycles -> ERRO, err_code=2. With erro_nivel=0, exit after 3 cycles to ENCHENDO.
5. erro_nivel pulse during IRRIGANDO -> ERRO next edge, valvula=0, err_code=1. Pattern 0,0,1,0,0,0 -> exit only after the last three zeros.
6. reset_n asserted mid-IRRIGANDO between clock edges -> valvula=0 and state=0 immediately. In CHEIO, erro_nivel=1 together with cheio and a request -> ERRO.
